// File: rtl/tx_cmd_probe_pkg.sv
// Shared types and constants for the TX command-path probe capture core.
// Optional build macro TX_CMD_PROBE_TIMESTAMP_EN adds a 32-bit cycle stamp to every sample.
package tx_cmd_probe_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StArmed,
    StPost,
    StDone
  } cap_state_e;

  // Bit positions of the 1-bit probes inside the trigger vector / mask.
  localparam int unsigned NumTrig = 7;
  localparam int unsigned TrigP0  = 0;
  localparam int unsigned TrigP1  = 1;
  localparam int unsigned TrigP3  = 2;
  localparam int unsigned TrigP4  = 3;
  localparam int unsigned TrigP10 = 4;
  localparam int unsigned TrigP15 = 5;
  localparam int unsigned TrigP16 = 6;

  // Seven 16-bit status probes (p6..p9, p11, p12, p14).
  localparam int unsigned NumNarrow = 7;
  localparam int unsigned NarrowW   = 16;

`ifdef TX_CMD_PROBE_TIMESTAMP_EN
  localparam int unsigned TsWidth = 32;
`else
  localparam int unsigned TsWidth = 0;
`endif

  // Width of one stored sample: 1-bit probes, 16-bit probes, two addresses, the command
  // word (dlen + addr), DMA data, plus the optional timestamp.
  function automatic int unsigned sample_width(input int unsigned addr_w,
                                               input int unsigned dlen_w,
                                               input int unsigned data_w);
    return NumTrig + NumNarrow * NarrowW + 2 * addr_w + dlen_w + addr_w + data_w + TsWidth;
  endfunction

endpackage

// File: rtl/tx_cmd_probe_capture_if.sv
// Control / read-back port of the probe capture core.
// master = software or bench side, slave = capture core.
interface tx_cmd_probe_capture_if
  import tx_cmd_probe_pkg::*;
#(
  parameter int unsigned AW = 10,
  parameter int unsigned SW = sample_width(32, 16, 64)
) ();

  logic               i_arm;
  logic               i_abort;
  logic [NumTrig-1:0] i_trig_mask;
  logic               i_trig_edge;
  logic [AW-1:0]      i_pre_cnt;
  logic [AW-1:0]      i_rd_idx;
  logic [SW-1:0]      o_rd_data;
  logic               o_busy;
  logic               o_done;
  logic [AW-1:0]      o_trig_addr;

  modport master (
    output i_arm, i_abort, i_trig_mask, i_trig_edge, i_pre_cnt, i_rd_idx,
    input  o_rd_data, o_busy, o_done, o_trig_addr
  );

  modport slave (
    input  i_arm, i_abort, i_trig_mask, i_trig_edge, i_pre_cnt, i_rd_idx,
    output o_rd_data, o_busy, o_done, o_trig_addr
  );

endinterface

// File: rtl/tx_cmd_probe_ram.sv
// Simple dual-port capture RAM: one write port, one registered read port.
module tx_cmd_probe_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 295,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port; the array itself has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read; only the output register is cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tx_cmd_probe_capture.sv
// Logic-analyzer style capture of the TLK2711 TX command path probes.
// Build macro TX_CMD_PROBE_TIMESTAMP_EN stores a free-running 32-bit cycle count in the
// MSBs of every sample.
module tx_cmd_probe_capture
  import tx_cmd_probe_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DLEN_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 1024,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned SW = sample_width(ADDR_WIDTH, DLEN_WIDTH, DATA_WIDTH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             probe0,
  input  logic                             probe1,
  input  logic [DLEN_WIDTH+ADDR_WIDTH-1:0] probe2,
  input  logic                             probe3,
  input  logic                             probe4,
  input  logic [ADDR_WIDTH-1:0]            probe5,
  input  logic [15:0]                      probe6,
  input  logic [15:0]                      probe7,
  input  logic [15:0]                      probe8,
  input  logic [15:0]                      probe9,
  input  logic                             probe10,
  input  logic [15:0]                      probe11,
  input  logic [15:0]                      probe12,
  input  logic [ADDR_WIDTH-1:0]            probe13,
  input  logic [15:0]                      probe14,
  input  logic                             probe15,
  input  logic                             probe16,
  input  logic [DATA_WIDTH-1:0]            probe17,
  tx_cmd_probe_capture_if.slave            ctl
);

  // i_pre_cnt is AW bits wide, so min(i_pre_cnt, DEPTH-1) never clips.
  localparam logic [AW-1:0] PreMax = AW'(DEPTH - 1);
  localparam logic [AW-1:0] One    = AW'(1);

  cap_state_e         state_q, state_d;
  logic [SW-1:0]      s_d, s_q;
  logic [NumTrig-1:0] trig_d, trig_q, trig_prev_q, trig_sel;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, fill_q, fill_d, post_q, post_d;
  logic [AW-1:0]      pre_q, pre_d, trig_addr_q, trig_addr_d, rd_addr;
  logic [SW-1:0]      rd_data;
  logic               hit, hit_take, start, busy, done, we;

`ifdef TX_CMD_PROBE_TIMESTAMP_EN
  logic [31:0] ts_q;

  // Free-running cycle stamp, wraps at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + 32'd1;
    end
  end

  assign s_d = {ts_q, probe17, probe16, probe15, probe14, probe13, probe12, probe11, probe10,
                probe9, probe8, probe7, probe6, probe5, probe4, probe3, probe2, probe1, probe0};
`else
  assign s_d = {probe17, probe16, probe15, probe14, probe13, probe12, probe11, probe10,
                probe9, probe8, probe7, probe6, probe5, probe4, probe3, probe2, probe1, probe0};
`endif

  // Gather the 1-bit probes into trigger-mask order.
  always_comb begin
    trig_d          = '0;
    trig_d[TrigP0]  = probe0;
    trig_d[TrigP1]  = probe1;
    trig_d[TrigP3]  = probe3;
    trig_d[TrigP4]  = probe4;
    trig_d[TrigP10] = probe10;
    trig_d[TrigP15] = probe15;
    trig_d[TrigP16] = probe16;
  end

  // Probe pipeline: trigger logic looks at the same delayed sample that is being written.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q         <= '0;
      trig_q      <= '0;
      trig_prev_q <= '0;
    end else begin
      s_q         <= s_d;
      trig_q      <= trig_d;
      trig_prev_q <= trig_q;
    end
  end

  assign trig_sel = ctl.i_trig_edge ? (trig_q & ~trig_prev_q) : trig_q;
  assign hit      = (ctl.i_trig_mask == '0) || ((trig_sel & ctl.i_trig_mask) != '0);
  assign start    = ctl.i_arm && !ctl.i_abort && (state_q == StIdle || state_q == StDone);
  assign hit_take = (state_q == StArmed) && hit && !ctl.i_abort;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; abort wins over everything except reset.
  always_comb begin
    state_d = state_q;
    if (ctl.i_abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: if (ctl.i_arm) state_d = (ctl.i_pre_cnt == '0) ? StArmed : StPre;
        StPre:          if (fill_q + One == pre_q) state_d = StArmed;
        StArmed:        if (hit) state_d = (pre_q == PreMax) ? StDone : StPost;
        StPost:         if (post_q == One) state_d = StDone;
        default:        state_d = StIdle;
      endcase
    end
  end

  // FSM outputs: the RAM is written in every busy state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StPre, StArmed, StPost: busy = 1'b1;
      StDone:                 done = 1'b1;
      default:                ;
    endcase
    we = busy;
  end

  // Write pointer, pre/post counters and trigger address bookkeeping.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    post_d      = post_q;
    pre_d       = pre_q;
    trig_addr_d = trig_addr_q;
    if (start) begin
      wr_ptr_d = '0;
      fill_d   = '0;
      pre_d    = ctl.i_pre_cnt;
    end else if (we) begin
      wr_ptr_d = wr_ptr_q + One;
      if (state_q == StPre) fill_d = fill_q + One;
      if (state_q == StPost) post_d = post_q - One;
      if (hit_take) begin
        trig_addr_d = wr_ptr_q;
        post_d      = PreMax - pre_q;
      end
    end
  end

  // Bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      post_q      <= '0;
      pre_q       <= '0;
      trig_addr_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      post_q      <= post_d;
      pre_q       <= pre_d;
      trig_addr_q <= trig_addr_d;
    end
  end

  // Index 0 of the read-back window is the oldest pre-trigger sample.
  assign rd_addr = trig_addr_q - pre_q + ctl.i_rd_idx;

  tx_cmd_probe_ram #(
    .DEPTH(DEPTH),
    .WIDTH(SW)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .we_i   (we),
    .waddr_i(wr_ptr_q),
    .wdata_i(s_q),
    .raddr_i(rd_addr),
    .rdata_o(rd_data)
  );

  assign ctl.o_rd_data   = rd_data;
  assign ctl.o_busy      = busy;
  assign ctl.o_done      = done;
  assign ctl.o_trig_addr = trig_addr_q;

endmodule

// File: tb/tb_tx_cmd_probe_capture.sv
// Scoreboard bench for tx_cmd_probe_capture (DEPTH = 16). Expected read-back samples are
// taken from a history of driven probe vectors, windowed around the trigger that a
// stream-level model locates.
module tb_tx_cmd_probe_capture;
  import tx_cmd_probe_pkg::*;

  localparam int D      = 16;
  localparam int AW     = 4;
  localparam int PW     = 295;
  localparam int SW     = sample_width(32, 16, 64);
  localparam int MaxCyc = 8192;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        probe0, probe1, probe3, probe4, probe10, probe15, probe16;
  logic [47:0] probe2;
  logic [31:0] probe5, probe13;
  logic [15:0] probe6, probe7, probe8, probe9, probe11, probe12, probe14;
  logic [63:0] probe17;
  logic [PW-1:0] pv;

  assign {probe17, probe16, probe15, probe14, probe13, probe12, probe11, probe10, probe9,
          probe8, probe7, probe6, probe5, probe4, probe3, probe2, probe1, probe0} = pv;

  tx_cmd_probe_capture_if #(.AW(AW), .SW(SW)) ctl ();

  tx_cmd_probe_capture #(
    .ADDR_WIDTH(32), .DLEN_WIDTH(16), .DATA_WIDTH(64), .DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst),
    .probe0(probe0), .probe1(probe1), .probe2(probe2), .probe3(probe3), .probe4(probe4),
    .probe5(probe5), .probe6(probe6), .probe7(probe7), .probe8(probe8), .probe9(probe9),
    .probe10(probe10), .probe11(probe11), .probe12(probe12), .probe13(probe13),
    .probe14(probe14), .probe15(probe15), .probe16(probe16), .probe17(probe17),
    .ctl(ctl)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;   // index of the next clock edge
  int arm_cyc  = 0;
  int plan_base = 0;
  logic [PW-1:0] hist  [MaxCyc];  // probe vector sampled at each edge
  logic [6:0]    thist [MaxCyc];  // its trigger bits {p16,p15,p10,p4,p3,p1,p0}
  logic [6:0]    plan  [$];       // scripted trigger bits from plan_base on
  logic          rd_req = 1'b0;
  logic [PW-1:0] exp_q  [$];
  string         name_q [$];

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // Drive one random probe vector (probe9 = cycles since arm), record it, advance one edge.
  task automatic tick();
    logic [6:0]  t;
    logic [63:0] r17, r2;
    int k;
    k = cyc - plan_base;
    if (k >= 0 && k < plan.size()) t = plan[k];
    else t = 7'($urandom & $urandom & $urandom);
    r17 = {$urandom, $urandom};
    r2  = {$urandom, $urandom};
    pv = {r17, t[6], t[5], 16'($urandom), 32'($urandom), 16'($urandom), 16'($urandom), t[4],
          16'(cyc - arm_cyc), 16'($urandom), 16'($urandom), 16'($urandom), 32'($urandom),
          t[3], t[2], r2[47:0], t[1], t[0]};
    if (cyc >= MaxCyc) begin
      $display("FAIL cycle_budget got=%0d want<%0d", cyc, MaxCyc);
      $fatal(1);
    end
    hist[cyc]  = pv;
    thist[cyc] = t;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Monitor: every edge that carried a read request must present the queued sample.
  always @(posedge clk) begin : mon
    logic pend;
    pend = rd_req;
    #1;
    if (pend) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected", ctl.o_rd_data[PW-1:0], '0);
      end else begin
        chk(name_q.pop_front(), ctl.o_rd_data[PW-1:0], exp_q.pop_front());
      end
    end
  end

  // One full capture: arm, wait for done, compare against the model, read all samples back.
  task automatic capture(input string nm, input logic [6:0] mask, input logic edge_m,
                         input int pre, input int rearm_at);
    int a, j, done_edge, exp_done, off, idx;
    logic [6:0] sel;
    ctl.i_trig_mask = mask;
    ctl.i_trig_edge = edge_m;
    ctl.i_pre_cnt   = AW'(pre);
    plan_base = cyc;
    arm_cyc   = cyc + 4;
    a         = arm_cyc;
    repeat (4) tick();
    ctl.i_arm = 1'b1;
    tick();
    ctl.i_arm = 1'b0;
    chk_i({nm, " busy_after_arm"}, int'(ctl.o_busy), 1);
    done_edge = -1;
    for (int n = 0; n < 300 && done_edge < 0; n++) begin
      if (n == rearm_at) ctl.i_arm = 1'b1;
      tick();
      ctl.i_arm = 1'b0;
      if (ctl.o_done) done_edge = cyc - 1;
    end
    // Write w stores the probes seen at edge a+w; the trigger is the first write at or
    // after the pre window whose trigger bits hit the mask.
    j = -1;
    for (int w = pre; a + w < cyc && j < 0; w++) begin
      sel = edge_m ? (thist[a+w] & ~thist[a+w-1]) : thist[a+w];
      if (mask == 7'd0 || (sel & mask) != 7'd0) j = w;
    end
    exp_done = (j < 0) ? -1 : a + j + D - pre;
    chk_i({nm, " done_edge"}, done_edge, exp_done);
    if (j >= 0 && done_edge == exp_done) begin
      chk_i({nm, " trig_addr"}, int'(ctl.o_trig_addr), j % D);
      off = $urandom_range(D - 1);
      for (int i = 0; i < D; i++) begin
        idx = (i + off) % D;
        ctl.i_rd_idx = AW'(idx);
        rd_req = 1'b1;
        exp_q.push_back(hist[a + j - pre + idx]);
        name_q.push_back($sformatf("%s rd[%0d]", nm, idx));
        tick();
      end
      rd_req = 1'b0;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    pv  = '0;
    ctl.i_arm = 1'b0;
    ctl.i_abort = 1'b0;
    ctl.i_trig_mask = '0;
    ctl.i_trig_edge = 1'b0;
    ctl.i_pre_cnt = '0;
    ctl.i_rd_idx = '0;
    repeat (3) tick();
    chk_i("reset busy", int'(ctl.o_busy), 0);
    chk_i("reset done", int'(ctl.o_done), 0);
    chk_i("reset trig_addr", int'(ctl.o_trig_addr), 0);
    chk("reset rd_data", ctl.o_rd_data[PW-1:0], '0);
    rst = 1'b0;
    tick();
    chk_i("idle busy", int'(ctl.o_busy), 0);
    chk_i("idle done", int'(ctl.o_done), 0);

    // Level trigger on p4 pulsed 10 cycles after arm, 4 pre samples.
    plan.delete();
    for (int k = 0; k < 24; k++) plan.push_back((k == 14) ? 7'b0001000 : 7'd0);
    capture("trig_p4", 7'b0001000, 1'b0, 4, -1);

    // Edge trigger: p0 high across arm, must fall and rise again before triggering.
    plan.delete();
    for (int k = 0; k < 22; k++) plan.push_back((k == 19 || k == 20) ? 7'd0 : 7'b0000001);
    capture("edge_p0", 7'b0000001, 1'b1, 2, -1);

    // Empty mask, no pre window: triggers on the first armed cycle at address 0.
    plan.delete();
    capture("mask0", 7'd0, 1'b0, 0, -1);
    ctl.i_abort = 1'b1;
    tick();
    ctl.i_abort = 1'b0;
    chk_i("abort_from_done done", int'(ctl.o_done), 0);

    // Full pre window, with an ignored re-arm while busy.
    plan.delete();
    for (int k = 0; k < 26; k++) plan.push_back((k == 24) ? 7'b0000010 : 7'd0);
    capture("pre15", 7'b0000010, 1'b0, D - 1, 3);

    // Reset in the middle of a capture.
    plan.delete();
    repeat (60) plan.push_back(7'd0);
    ctl.i_trig_mask = 7'b0001000;
    ctl.i_trig_edge = 1'b0;
    ctl.i_pre_cnt = AW'(3);
    plan_base = cyc;
    arm_cyc = cyc + 1;
    tick();
    ctl.i_arm = 1'b1;
    tick();
    ctl.i_arm = 1'b0;
    repeat (6) tick();
    chk_i("rst_mid busy_before", int'(ctl.o_busy), 1);
    rst = 1'b1;
    repeat (2) tick();
    chk_i("rst_mid busy", int'(ctl.o_busy), 0);
    chk_i("rst_mid done", int'(ctl.o_done), 0);
    chk_i("rst_mid trig_addr", int'(ctl.o_trig_addr), 0);
    chk("rst_mid rd_data", ctl.o_rd_data[PW-1:0], '0);
    rst = 1'b0;
    tick();

    // Abort while in the post-trigger phase, then abort beats a simultaneous arm.
    plan.delete();
    ctl.i_trig_mask = 7'd0;
    ctl.i_pre_cnt = '0;
    ctl.i_arm = 1'b1;
    tick();
    ctl.i_arm = 1'b0;
    repeat (4) tick();
    chk_i("abort busy_in_post", int'(ctl.o_busy), 1);
    ctl.i_abort = 1'b1;
    tick();
    ctl.i_abort = 1'b0;
    chk_i("abort busy", int'(ctl.o_busy), 0);
    chk_i("abort done", int'(ctl.o_done), 0);
    ctl.i_abort = 1'b1;
    ctl.i_arm = 1'b1;
    tick();
    ctl.i_abort = 1'b0;
    ctl.i_arm = 1'b0;
    repeat (3) tick();
    chk_i("abort_over_arm busy", int'(ctl.o_busy), 0);

    // Randomised captures.
    for (int r = 0; r < 6; r++) begin
      plan.delete();
      capture($sformatf("rand%0d", r), 7'($urandom_range(1, 127)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, D - 1)), int'($urandom_range(0, D - 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
